// File: rtl/kbd_pkg.sv
// -----------------------------------------------------------------------------
// kbd_pkg
// Shared definitions for the PS/2 keyboard receiver:
//   - receive FSM state encoding
//   - PS/2 frame length and frame-check helper
//   - bit positions of the data and status read words
//   - keyboard region nibble of the CPU data address (dmem_addr[29:26])
// -----------------------------------------------------------------------------
package kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } kbd_state_t;

    // Start + 8 data + parity + stop.
    localparam int FRAME_LEN = 11;

    // Bits captured after the start bit (data, parity, stop).
    localparam int FRAME_TAIL_BITS = FRAME_LEN - 1;

    // dmem_addr[29:26] value that selects the keyboard region.
    localparam logic [3:0] KBD_REGION = 4'he;

    // Data word: {23'b0, valid, byte}.
    localparam int DATA_VALID_BIT = 8;

    // Status word layout.
    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_TMO_BIT   = 3;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_PERR_LSB  = 16;

    // tail = {stop, parity, d7..d0}. A frame is good when the stop bit is 1
    // and data plus parity hold an odd number of ones.
    function automatic logic frame_ok(input logic [FRAME_TAIL_BITS-1:0] tail);
        return tail[FRAME_TAIL_BITS-1] & (^tail[FRAME_TAIL_BITS-2:0]);
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// -----------------------------------------------------------------------------
// kbd_fifo
// Synchronous scancode FIFO with a combinational head.
//   i_clk          clock
//   i_rst          synchronous active-low reset (pointers and count only)
//   i_push         write i_wdata; accepted when not full, or when full and a
//                  pop happens in the same cycle
//   i_pop          remove the head entry; ignored when empty
//   i_wdata        byte to write
//   o_head         entry at the read pointer (undefined content when empty)
//   o_count        number of stored entries
//   o_count_next   value o_count takes at the next edge
//   o_full/o_empty occupancy flags
// DEPTH must be a power of 2 and at least 2 so pointers wrap naturally.
// -----------------------------------------------------------------------------
module kbd_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [7:0]              i_wdata,
    output logic [7:0]              o_head,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic [$clog2(DEPTH):0]  o_count_next,
    output logic                    o_full,
    output logic                    o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CW'(DEPTH));
    assign o_count  = r_count;
    assign o_head   = r_mem[r_rd_ptr];

    // When full, the write slot equals the read slot; the head is consumed
    // combinationally this cycle, so overwriting it at the edge is safe.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_comb begin
        o_count_next = r_count;
        if (w_do_push && !w_do_pop) begin
            o_count_next = r_count + CW'(1);
        end else if (w_do_pop && !w_do_push) begin
            o_count_next = r_count - CW'(1);
        end
    end

    // Storage carries data only and is left out of reset.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= o_count_next;
        end
    end

endmodule

// File: rtl/kbd_ps2_ctrl.sv
// -----------------------------------------------------------------------------
// kbd_ps2_ctrl
// PS/2 keyboard receiver for the memory-mapped keyboard region of the CPU
// data interface. Deframes 11-bit PS/2 frames, buffers good scancodes in a
// FIFO and presents either the FIFO head or a status word combinationally.
//   i_clk        pipeline clock (single domain)
//   i_rst        synchronous active-low reset
//   i_ps2_clk    raw PS/2 clock (asynchronous)
//   i_ps2_data   raw PS/2 data (asynchronous)
//   i_rd_en      data read to the keyboard region
//   i_stall_in   pipeline stall; read side effects suppressed while high
//   i_addr_sel   0: data word, 1: status word
//   o_data_out   data word  {23'b0, ~empty, head_byte (00 when empty)}
//                status word{8'b0, perr_cnt, count, 4'b0, tmo, ovf, full, empty}
//   o_irq        registered, high while the FIFO holds data
// -----------------------------------------------------------------------------
module kbd_ps2_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ps2_clk,
    input  logic        i_ps2_data,
    input  logic        i_rd_en,
    input  logic        i_stall_in,
    input  logic        i_addr_sel,
    output logic [31:0] o_data_out,
    output logic        o_irq
);

    import kbd_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT = 4'(FRAME_TAIL_BITS - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    // Synchronizers and edge detect
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    logic                   w_clk_s;
    logic                   w_dat_s;
    logic                   w_fall;

    // Receive FSM
    kbd_state_t                r_state;
    logic [3:0]                r_bit_cnt;
    logic [FRAME_TAIL_BITS-1:0] r_shift;
    logic [TW-1:0]             r_tmo_cnt;

    // FIFO and status
    logic          w_push;
    logic          w_pop;
    logic          w_perr_evt;
    logic          w_tmo_evt;
    logic          w_ovf_evt;
    logic          w_status_rd;
    logic [7:0]    w_head;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    r_perr_cnt;
    logic          r_ovf;
    logic          r_tmo;
    logic          r_irq;
    logic [31:0]   w_status;

    // ---- stage: line synchronizers ----
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync[0] <= i_ps2_clk;
            r_dat_sync[0] <= i_ps2_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_clk_sync[i] <= r_clk_sync[i-1];
                r_dat_sync[i] <= r_dat_sync[i-1];
            end
            r_clk_prev <= w_clk_s;
        end
    end

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
    assign w_fall  = r_clk_prev & ~w_clk_s;

    // ---- stage: frame deserializer ----
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tmo_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fall && !w_dat_s) begin
                        r_state   <= ST_RECV;
                        r_bit_cnt <= '0;
                        r_tmo_cnt <= '0;
                    end
                end
                ST_RECV: begin
                    if (w_fall) begin
                        // LSB-first: after the stop bit the register holds
                        // {stop, parity, d7..d0}.
                        r_shift   <= {w_dat_s, r_shift[FRAME_TAIL_BITS-1:1]};
                        r_tmo_cnt <= '0;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= ST_CHECK;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
                end
                ST_CHECK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_push     = (r_state == ST_CHECK) &  frame_ok(r_shift);
    assign w_perr_evt = (r_state == ST_CHECK) & ~frame_ok(r_shift);
    assign w_tmo_evt  = (r_state == ST_RECV) & ~w_fall & (r_tmo_cnt == TMO_LAST);

    // ---- stage: scancode buffer ----
    assign w_pop       = i_rd_en & ~i_stall_in & ~i_addr_sel & ~w_empty;
    assign w_status_rd = i_rd_en & ~i_stall_in &  i_addr_sel;
    assign w_ovf_evt   = w_push & w_full & ~w_pop;

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_wdata      (r_shift[7:0]),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_count_next (w_count_next),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    // ---- stage: status flags and interrupt ----
    // A status read clears the flags, but an event landing in the same
    // cycle takes priority so it is never lost.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_perr_cnt <= '0;
            r_ovf      <= 1'b0;
            r_tmo      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_perr_evt) begin
                r_perr_cnt <= w_status_rd ? 8'd1 : sat_inc8(r_perr_cnt);
            end else if (w_status_rd) begin
                r_perr_cnt <= '0;
            end

            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (w_status_rd) begin
                r_ovf <= 1'b0;
            end

            if (w_tmo_evt) begin
                r_tmo <= 1'b1;
            end else if (w_status_rd) begin
                r_tmo <= 1'b0;
            end

            r_irq <= (w_count_next != '0);
        end
    end

    assign o_irq = r_irq;

    // ---- stage: read data mux ----
    always_comb begin
        w_status                               = '0;
        w_status[STAT_EMPTY_BIT]               = w_empty;
        w_status[STAT_FULL_BIT]                = w_full;
        w_status[STAT_OVF_BIT]                 = r_ovf;
        w_status[STAT_TMO_BIT]                 = r_tmo;
        w_status[STAT_COUNT_LSB +: 8]          = 8'(w_count);
        w_status[STAT_PERR_LSB +: 8]           = r_perr_cnt;

        if (i_addr_sel) begin
            o_data_out = w_status;
        end else begin
            o_data_out                 = '0;
            o_data_out[DATA_VALID_BIT] = ~w_empty;
            o_data_out[7:0]            = w_empty ? 8'h00 : w_head;
        end
    end

endmodule

// File: tb/tb_kbd_ps2_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kbd_ps2_ctrl
// Scoreboard bench for kbd_ps2_ctrl. The stimulus side drives PS/2 frames and
// CPU reads and keeps a queue of the bytes the keyboard FIFO should hold; a
// separate monitor pops that queue on every unstalled data read and compares.
// -----------------------------------------------------------------------------
module tb_kbd_ps2_ctrl;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;
    localparam int SYNC  = 2;
    localparam int HALF  = 12;   // clk cycles per PS/2 half period

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic        rd_en    = 1'b0;
    logic        stall    = 1'b0;
    logic        addr_sel = 1'b0;
    logic [31:0] data_out;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] sb_q[$];
    int         m_perr = 0;
    bit         m_ovf  = 1'b0;
    bit         m_tmo  = 1'b0;

    always #5 clk = ~clk;

    kbd_ps2_ctrl #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .i_rd_en    (rd_en),
        .i_stall_in (stall),
        .i_addr_sel (addr_sel),
        .o_data_out (data_out),
        .o_irq      (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {8'h00, 8'(m_perr), 8'(sb_q.size()), 4'h0,
                m_tmo, m_ovf, (sb_q.size() == DEPTH), (sb_q.size() == 0)};
    endfunction

    // Monitor: every unstalled data read pops the expected queue.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && rd_en && !stall && !addr_sel) begin
                if (sb_q.size() == 0) begin
                    check("data_read_empty", data_out, 32'h0);
                end else begin
                    exp = {23'b0, 1'b1, sb_q[0]};
                    check("data_read_pop", data_out, exp);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    // Whole frame. pop_at_end issues one data read timed to land on the
    // same clock edge as the FIFO push of this frame.
    task automatic send_frame(input logic [7:0] b, input bit par_flip,
                              input bit stop_bad, input bit pop_at_end);
        logic [10:0] bits;
        bit          ok;
        bits[0]    = 1'b0;
        bits[8:1]  = b;
        bits[9]    = (~^b) ^ par_flip;
        bits[10]   = ~stop_bad;
        ok = bits[10] && (^bits[9:1]);
        if (ok) begin
            if (sb_q.size() < DEPTH || pop_at_end) sb_q.push_back(b);
            else m_ovf = 1'b1;
        end else if (m_perr < 255) begin
            m_perr++;
        end
        for (int i = 0; i < 11; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (pop_at_end && i == 10) begin
                repeat (SYNC + 1) @(negedge clk);
                addr_sel = 1'b0;
                rd_en    = 1'b1;
                @(negedge clk);
                rd_en    = 1'b0;
                repeat (HALF - SYNC - 2) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_partial(input int nbits, input logic [10:0] bits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic read_data();
        addr_sel = 1'b0;
        rd_en    = 1'b1;
        @(negedge clk);
        rd_en    = 1'b0;
    endtask

    // Status read with side effects (clears flags).
    task automatic read_status(input string name);
        addr_sel = 1'b1;
        rd_en    = 1'b1;
        #2;
        check(name, data_out, exp_status());
        @(negedge clk);
        rd_en    = 1'b0;
        addr_sel = 1'b0;
        m_perr   = 0;
        m_ovf    = 1'b0;
        m_tmo    = 1'b0;
    endtask

    // Status read under stall: no side effects.
    task automatic peek_status(input string name);
        addr_sel = 1'b1;
        rd_en    = 1'b1;
        stall    = 1'b1;
        #2;
        check(name, data_out, exp_status());
        @(negedge clk);
        rd_en    = 1'b0;
        stall    = 1'b0;
        addr_sel = 1'b0;
    endtask

    task automatic check_irq(input string name);
        check(name, {31'b0, irq}, {31'b0, sb_q.size() != 0});
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() > 0 && guard < 2 * DEPTH) begin
            read_data();
            guard++;
        end
        check("drain_done", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp;
        int          r;

        // Reset state
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check("reset_data", data_out, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        peek_status("reset_status");

        // Test 1: good frame 0x1C
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        peek_status("t1_status");
        check_irq("t1_irq_set");
        addr_sel = 1'b0;
        rd_en    = 1'b1;
        #2;
        check("t1_data", data_out, 32'h0000011C);
        @(negedge clk);
        rd_en = 1'b0;
        check_irq("t1_irq_clear");
        peek_status("t1_status_empty");

        // Test 2: parity error
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        read_status("t2_perr_one");
        read_status("t2_perr_cleared");

        // Test 3: overflow and pointer wrap
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        check("t3_model_count", 32'(sb_q.size()), 32'd8);
        read_status("t3_full_ovf");
        drain();

        // Test 4: held read under stall pops exactly once
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        exp = {23'b0, 1'b1, sb_q[0]};
        addr_sel = 1'b0;
        rd_en    = 1'b1;
        stall    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            check("t4_stall_data", data_out, exp);
            @(negedge clk);
        end
        stall = 1'b0;
        @(negedge clk);
        rd_en = 1'b0;
        peek_status("t4_one_pop");
        drain();

        // Test 5: timeout on a partial frame
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        send_partial(5, 11'b000_0000_1010);
        repeat (TMO + 20) @(negedge clk);
        m_tmo = 1'b1;
        peek_status("t5_tmo_peek");
        read_status("t5_tmo_read");
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        peek_status("t5_after");
        drain();

        // Test 6: push and pop on the same edge while full
        for (int i = 0; i < DEPTH; i++) send_frame(8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        peek_status("t6_full_no_ovf");
        drain();

        // Reset in the middle of a frame
        send_frame(8'h21, 1'b0, 1'b0, 1'b0);
        send_partial(4, 11'b000_0000_0110);
        rst_n = 1'b0;
        sb_q.delete();
        m_perr = 0;
        m_ovf  = 1'b0;
        m_tmo  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        peek_status("rst_mid_status");
        check_irq("rst_mid_irq");
        send_frame(8'h77, 1'b0, 1'b0, 1'b0);
        drain();

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 4)      send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
            else if (r == 5) send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
            else if (r == 6) send_frame(8'($urandom), 1'b0, 1'b1, 1'b0);
            else if (r <= 8) read_data();
            else             read_status("rand_status");
            check_irq("rand_irq");
        end
        read_status("final_status");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kbd_ps2_ctrl.md
Name: kbd_ps2_ctrl

Overview:
PS/2 keyboard receiver for the memory-mapped keyboard region (dmem_addr[29:26] == 4'he) of the CPU memory interface.
- Samples the external PS/2 clock/data lines and deframes 11-bit scancode frames.
- Buffers received scancodes in a small FIFO.
- Returns the FIFO head or a status word combinationally on the data-read path, so the interface can mux it straight onto dmem_data_out.
- Runs in the pipeline clock domain.

Parameters:
- FIFO_DEPTH, 8, scancode FIFO entries; must be a power of 2, at least 2.
- TIMEOUT_CYCLES, 50000, clk cycles without a PS/2 falling edge before a partial frame is aborted.
- SYNC_STAGES, 2, flip-flop stages on ps2_clk/ps2_data.

Ports:
- clk  in  1  pipeline clock (clk_pipeline); single clock domain.
- rst  in  1  synchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock; asynchronous to clk.
- ps2_data  in  1  raw PS/2 data; asynchronous to clk.
- rd_en  in  1  data read to keyboard region (dmem_read_in & region hit).
- stall_in  in  1  pipeline mem_stall; side effects are suppressed while high.
- addr_sel  in  1  dmem_addr[0]: 0 selects the data word, 1 selects the status word.
- data_out  out  32  combinational read data.
- irq  out  1  registered; high while the FIFO is non-empty.

Behaviour:
- Reset (rst==0 at posedge clk):
  - FSM goes to IDLE; FIFO pointers and count cleared.
  - Sticky flags, error counter, shift register and timeout counter cleared.
  - Synchronizers load 1.
  - irq=0.
- Synchronizers: SYNC_STAGES flops per line. A falling edge is registered prev=1, cur=0 on the synchronized ps2_clk. All frame logic acts only on falling-edge cycles.
- FSM:
  - IDLE: on a falling edge with data==0 (start bit), go to RECV, bit_cnt=0, timeout=0. A falling edge with data==1 is ignored.
  - RECV: each falling edge shifts data in LSB-first; bit_cnt counts 0..9 (8 data, parity, stop). After the 10th bit (stop) go to CHECK.
  - CHECK (one cycle):
    - Valid frame: stop==1 and the XOR of 8 data bits and parity ==1 (odd parity). The byte is pushed.
    - Bad frame: parity_err_cnt increments, saturating at 8'hFF; the byte is dropped.
    - Then go to IDLE.
  - Timeout: in RECV, the counter increments on every cycle with no falling edge and clears on each edge. When it reaches TIMEOUT_CYCLES-1, go to IDLE, drop the partial frame, and set the timeout sticky flag.
  - Reset mid-frame discards the partial frame.
- FIFO:
  - pop = rd_en & ~stall_in & ~addr_sel & ~empty.
  - push occurs only from CHECK with a valid frame.
  - Push when full and no pop: byte dropped, overflow sticky set.
  - Push and pop in the same cycle are both performed, including when full (count unchanged) and when count==1.
  - Pointers wrap modulo FIFO_DEPTH. count width is clog2(FIFO_DEPTH)+1.
- data_out, combinational, zero-latency:
  - addr_sel=0: {23'b0, ~empty, head_byte}. When empty, the low byte is 8'h00.
  - addr_sel=1: {8'b0, parity_err_cnt[7:0], count zero-extended to 8, 4'b0, timeout_sticky, overflow_sticky, full, empty}.
- Status read side effect: rd_en & ~stall_in & addr_sel clears parity_err_cnt, overflow_sticky and timeout_sticky at the next edge.
  - An event in that same cycle wins: the flag stays set, or the counter becomes 1.
- irq: irq <= (count_next != 0).

Decomposition:
- Shared package kbd_pkg:
  - FSM state encoding (IDLE, RECV, CHECK).
  - Status bit indices.
  - Frame length constant (11).
  - Keyboard region nibble constant 4'he.
- One sub-module, kbd_fifo: synchronous FIFO with push/pop/count/full/empty and a combinational head.

Test Plan:
1. Reset, then frame for 8'h1C (start 0, data LSB-first, parity 0, stop 1), PS/2 clock ~10 kHz → status count=1, empty=0; data read returns 32'h0000011C; after one unstalled read, status empty=1 and irq=0.
2. Frame 8'h1C with parity 1 → byte dropped, status [23:16]=8'h01; a second unstalled status read returns 8'h00 in that field.
3. Nine valid frames 8'h01..8'h09, no reads → count=8, full=1, overflow=1; eight pops return 8'h01..8'h08 in order with the pointers wrapping.
4. rd_en held with stall_in=1 for 5 cycles, then stall_in=0 for 1 cycle → exactly one pop; data_out constant throughout the stall.
5. Start bit plus 4 bits, then idle TIMEOUT_CYCLES → FSM returns to IDLE, timeout_sticky=1, count unchanged; a following full frame 8'h5A is received correctly.
6. FIFO full, valid frame completes in the same cycle as an unstalled pop → count stays 8, no overflow, the new byte appears last.
